// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if
// Groups the request/grant handshake and the bus transaction strobes shared
// between the requesting masters and the round-robin bus arbiter.
//
// Signals:
//   request             per-master level request (masters -> arbiter)
//   granted             one-hot registered grant (arbiter -> masters)
//   begin_transactionIN bus begin strobe from the granted master
//   end_transactionIN   bus end strobe
//   errorIN             bus error, terminates the transaction
//   active_master       index of the current or last grantee
//   bus_idle            high when no grant is active
//   timeout_pulse       one-cycle pulse when a grant is revoked by timeout
//
// Modports:
//   master  the requesting side (drives request and strobes)
//   slave   the arbiter side (drives grant and status)
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IdxW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] granted;
  logic                   begin_transactionIN;
  logic                   end_transactionIN;
  logic                   errorIN;
  logic [IdxW-1:0]        active_master;
  logic                   bus_idle;
  logic                   timeout_pulse;

  modport master (
    output request,
    output begin_transactionIN,
    output end_transactionIN,
    output errorIN,
    input  granted,
    input  active_master,
    input  bus_idle,
    input  timeout_pulse
  );

  modport slave (
    input  request,
    input  begin_transactionIN,
    input  end_transactionIN,
    input  errorIN,
    output granted,
    output active_master,
    output bus_idle,
    output timeout_pulse
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr
// Round-robin arbiter sharing the single system bus master port among
// NUM_MASTERS requesters. A one-hot grant is issued from IDLE, held through
// the whole bus transaction (tracked by the begin/end/error strobes), then
// dropped for one turnaround cycle while the priority pointer rotates past
// the master just served.
//
// Ports:
//   system_clock  bus clock, all state on the rising edge
//   system_reset  asynchronous, active-low reset
//   arb_if        bus_arbiter_rr_if.slave: request, strobes in;
//                 granted, active_master, bus_idle, timeout_pulse out
//
// Parameters:
//   NUM_MASTERS    number of requesters (2..8)
//   GRANT_TIMEOUT  cycles a grant may sit in GRANTED without a begin strobe
//
// Optional feature macro: ARB_GRANT_TIMEOUT_EN
//   Defined:   an unused grant is revoked after GRANT_TIMEOUT cycles and
//              timeout_pulse fires for one cycle alongside the revocation.
//   Undefined: a grant waits indefinitely; timeout_pulse is tied low.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS   = 4,
  parameter int GRANT_TIMEOUT = 16
) (
  input logic             system_clock,
  input logic             system_reset,
  bus_arbiter_rr_if.slave arb_if
);
  localparam int IdxW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    BUSY,
    RELEASE
  } state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] granted_q;
  logic [IdxW-1:0]        activeMaster_q;
  logic [IdxW-1:0]        lastPtr_q;
  logic                   timeoutPulse_q;
  logic [IdxW-1:0]        winner_d;
  logic                   winnerValid_d;
  logic                   timeoutHit;
  logic                   txnDone;

  // Single-beat transactions and normal completions both end on end or error.
  assign txnDone = arb_if.end_transactionIN | arb_if.errorIN;

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam int CntW = $clog2(GRANT_TIMEOUT + 1);
  logic [CntW-1:0] grantCount_q;

  // The counter holds the number of completed GRANTED cycles, so the cycle in
  // which it reads GRANT_TIMEOUT-1 is the one whose edge makes it reach the
  // limit; that edge revokes the grant.
  assign timeoutHit = (grantCount_q == CntW'(GRANT_TIMEOUT - 1));
`else
  // GRANT_TIMEOUT is never negative, so this is constant 0; referencing it
  // keeps the parameter in use when the timeout is compiled out.
  assign timeoutHit = (GRANT_TIMEOUT < 0);
`endif

  // Rotating priority scan: start one past the last grantee and take the
  // first requesting master, wrapping around the end of the vector.
  always_comb begin
    winner_d      = '0;
    winnerValid_d = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      if (!winnerValid_d && arb_if.request[(int'(lastPtr_q) + i) % NUM_MASTERS]) begin
        winner_d      = IdxW'((int'(lastPtr_q) + i) % NUM_MASTERS);
        winnerValid_d = 1'b1;
      end
    end
  end

  // Arbitration FSM. Every output is registered here so grant edges are clean
  // even when requests change in the cycle the decision is taken. Grants are
  // cleared on the transition into RELEASE so the bus sees a full turnaround
  // cycle with no owner.
  always_ff @(posedge system_clock or negedge system_reset) begin
    if (!system_reset) begin
      state_q        <= IDLE;
      granted_q      <= '0;
      activeMaster_q <= '0;
      lastPtr_q      <= IdxW'(NUM_MASTERS - 1);
      timeoutPulse_q <= 1'b0;
`ifdef ARB_GRANT_TIMEOUT_EN
      grantCount_q   <= '0;
`endif
    end else begin
      timeoutPulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winnerValid_d) begin
            state_q        <= GRANTED;
            granted_q      <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner_d;
            activeMaster_q <= winner_d;
`ifdef ARB_GRANT_TIMEOUT_EN
            grantCount_q   <= '0;
`endif
          end
        end
        GRANTED: begin
`ifdef ARB_GRANT_TIMEOUT_EN
          grantCount_q <= grantCount_q + 1'b1;
`endif
          if (arb_if.begin_transactionIN) begin
            if (txnDone) begin
              state_q   <= RELEASE;
              granted_q <= '0;
            end else begin
              state_q <= BUSY;
            end
          end else if (timeoutHit) begin
            state_q        <= RELEASE;
            granted_q      <= '0;
            timeoutPulse_q <= 1'b1;
          end else if (!arb_if.request[activeMaster_q]) begin
            state_q   <= RELEASE;
            granted_q <= '0;
          end
        end
        BUSY: begin
          if (txnDone) begin
            state_q   <= RELEASE;
            granted_q <= '0;
          end
        end
        RELEASE: begin
          lastPtr_q <= activeMaster_q;
          state_q   <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          granted_q <= '0;
        end
      endcase
    end
  end

  assign arb_if.granted       = granted_q;
  assign arb_if.active_master = activeMaster_q;
  assign arb_if.bus_idle      = ~|granted_q;
  assign arb_if.timeout_pulse = timeoutPulse_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr
// Self-checking bench for bus_arbiter_rr. Inputs are driven and outputs are
// sampled on the falling clock edge. Expected grants come from a rotating
// priority model (lastServed plus a rotate-and-search of the request vector).
module tb_bus_arbiter_rr;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic system_clock = 1'b0;
  logic system_reset = 1'b0;
  int   checks       = 0;
  int   failures     = 0;
  int   lastServed   = N - 1;

  bus_arbiter_rr_if #(.NUM_MASTERS(N)) arbIf ();

  bus_arbiter_rr #(
    .NUM_MASTERS  (N),
    .GRANT_TIMEOUT(TMO)
  ) dut (
    .system_clock(system_clock),
    .system_reset(system_reset),
    .arb_if      (arbIf.slave)
  );

  always #5 system_clock = ~system_clock;

  // Rotate the request vector so the master after lastServed sits at bit 0,
  // then take the lowest set bit.
  function automatic int expWinner(input logic [N-1:0] req, input int last);
    logic [2*N-1:0] both;
    int             start;
    start = (last + 1) % N;
    both  = {req, req} >> start;
    for (int i = 0; i < N; i++) begin
      if (both[i]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oneHot(input int w);
    logic [N-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // One transaction starting from IDLE with request low.
  // kind 0: begin after d1 cycles (stray end/error before begin), end or
  //         error d2 cycles later; kind 1: single beat; kind 2: withdraw.
  task automatic runTransaction(input logic [N-1:0] req, input int kind,
                                input int d1, input int d2);
    int           w;
    logic [N-1:0] eg;
    logic [1:0]   ew;
    w  = expWinner(req, lastServed);
    eg = oneHot(w);
    ew = 2'(w);
    arbIf.request = req;
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== eg || arbIf.active_master !== ew || arbIf.bus_idle !== 1'b0) begin
      failures++;
      $display("[TB] FAIL txn_grant req=%b: granted=%b active=%0d idle=%b, expected granted=%b active=%0d idle=0",
               req, arbIf.granted, arbIf.active_master, arbIf.bus_idle, eg, ew);
    end
    repeat (d1) begin
      if (kind == 0) begin
        arbIf.end_transactionIN = 1'($urandom_range(0, 1));
        arbIf.errorIN           = 1'($urandom_range(0, 1));
      end
      @(negedge system_clock);
      checks++;
      if (arbIf.granted !== eg) begin
        failures++;
        $display("[TB] FAIL txn_wait_hold: granted=%b expected=%b", arbIf.granted, eg);
      end
    end
    arbIf.end_transactionIN = 1'b0;
    arbIf.errorIN           = 1'b0;
    case (kind)
      0: begin
        arbIf.begin_transactionIN = 1'b1;
        @(negedge system_clock);
        arbIf.begin_transactionIN = 1'b0;
        if ($urandom_range(0, 1) == 1) arbIf.request[w] = 1'b0;
        checks++;
        if (arbIf.granted !== eg) begin
          failures++;
          $display("[TB] FAIL txn_busy_enter: granted=%b expected=%b", arbIf.granted, eg);
        end
        repeat (d2) begin
          arbIf.begin_transactionIN = 1'($urandom_range(0, 1));
          @(negedge system_clock);
          checks++;
          if (arbIf.granted !== eg) begin
            failures++;
            $display("[TB] FAIL txn_busy_hold: granted=%b expected=%b", arbIf.granted, eg);
          end
        end
        arbIf.begin_transactionIN = 1'b0;
        if ($urandom_range(0, 1) == 1) arbIf.end_transactionIN = 1'b1;
        else                           arbIf.errorIN           = 1'b1;
      end
      1: begin
        arbIf.begin_transactionIN = 1'b1;
        if ($urandom_range(0, 1) == 1) arbIf.end_transactionIN = 1'b1;
        else                           arbIf.errorIN           = 1'b1;
      end
      default: begin
        arbIf.request[w] = 1'b0;
      end
    endcase
    @(negedge system_clock);
    arbIf.begin_transactionIN = 1'b0;
    arbIf.end_transactionIN   = 1'b0;
    arbIf.errorIN             = 1'b0;
    arbIf.request             = '0;
    checks++;
    if (arbIf.granted !== '0 || arbIf.bus_idle !== 1'b1 || arbIf.active_master !== ew ||
        arbIf.timeout_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL txn_release kind=%0d: granted=%b idle=%b active=%0d tpulse=%b, expected 0000/1/%0d/0",
               kind, arbIf.granted, arbIf.bus_idle, arbIf.active_master, arbIf.timeout_pulse, ew);
    end
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== '0 || arbIf.active_master !== ew) begin
      failures++;
      $display("[TB] FAIL txn_idle: granted=%b active=%0d, expected 0000/%0d",
               arbIf.granted, arbIf.active_master, ew);
    end
    lastServed = w;
  endtask

  task automatic test_reset();
    system_reset              = 1'b0;
    arbIf.request             = '0;
    arbIf.begin_transactionIN = 1'b0;
    arbIf.end_transactionIN   = 1'b0;
    arbIf.errorIN             = 1'b0;
    repeat (3) @(negedge system_clock);
    checks++;
    if (arbIf.granted !== '0 || arbIf.active_master !== 2'd0 || arbIf.bus_idle !== 1'b1 ||
        arbIf.timeout_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: granted=%b active=%0d idle=%b tpulse=%b, expected 0000/0/1/0",
               arbIf.granted, arbIf.active_master, arbIf.bus_idle, arbIf.timeout_pulse);
    end
    system_reset = 1'b1;
    lastServed   = N - 1;
    @(negedge system_clock);
  endtask

  task automatic test_first_grant();
    runTransaction(4'b0100, 0, 2, 3);
  endtask

  task automatic test_round_robin();
    int           w;
    logic [N-1:0] eg;
    system_reset = 1'b0;
    @(negedge system_clock);
    system_reset = 1'b1;
    lastServed   = N - 1;
    arbIf.request = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w  = expWinner(4'b1111, lastServed);
      eg = oneHot(w);
      @(negedge system_clock);
      checks++;
      if (arbIf.granted !== eg) begin
        failures++;
        $display("[TB] FAIL rr_grant_%0d: granted=%b expected=%b", g, arbIf.granted, eg);
      end
      arbIf.begin_transactionIN = 1'b1;
      @(negedge system_clock);
      arbIf.begin_transactionIN = 1'b0;
      repeat (2) begin
        @(negedge system_clock);
        checks++;
        if (arbIf.granted !== eg) begin
          failures++;
          $display("[TB] FAIL rr_hold_%0d: granted=%b expected=%b", g, arbIf.granted, eg);
        end
      end
      arbIf.end_transactionIN = 1'b1;
      @(negedge system_clock);
      arbIf.end_transactionIN = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (arbIf.granted !== '0) begin
          failures++;
          $display("[TB] FAIL rr_gap_%0d_%0d: granted=%b expected=0000", g, k, arbIf.granted);
        end
        if (k == 0) @(negedge system_clock);
      end
      lastServed = w;
    end
    arbIf.request = '0;
    @(negedge system_clock);
  endtask

  task automatic test_single_beat();
    int w;
    lastServed    = 0;
    arbIf.request = 4'b0110;
    w = expWinner(4'b0110, lastServed);
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== oneHot(w)) begin
      failures++;
      $display("[TB] FAIL sb_grant: granted=%b expected=%b", arbIf.granted, oneHot(w));
    end
    arbIf.begin_transactionIN = 1'b1;
    arbIf.end_transactionIN   = 1'b1;
    @(negedge system_clock);
    arbIf.begin_transactionIN = 1'b0;
    arbIf.end_transactionIN   = 1'b0;
    checks++;
    if (arbIf.granted !== '0) begin
      failures++;
      $display("[TB] FAIL sb_release: granted=%b expected=0000", arbIf.granted);
    end
    lastServed = w;
    w = expWinner(4'b0110, lastServed);
    @(negedge system_clock);
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== oneHot(w)) begin
      failures++;
      $display("[TB] FAIL sb_next_grant: granted=%b expected=%b", arbIf.granted, oneHot(w));
    end
    arbIf.request = '0;
    @(negedge system_clock);
    @(negedge system_clock);
    lastServed = w;
  endtask

  task automatic test_busy_hold();
    int           w;
    logic [N-1:0] eg;
    arbIf.request = 4'b0100;
    w  = expWinner(4'b0100, lastServed);
    eg = oneHot(w);
    @(negedge system_clock);
    arbIf.begin_transactionIN = 1'b1;
    @(negedge system_clock);
    arbIf.request = '0;
    repeat (4) begin
      @(negedge system_clock);
      checks++;
      if (arbIf.granted !== eg) begin
        failures++;
        $display("[TB] FAIL busy_hold: granted=%b expected=%b", arbIf.granted, eg);
      end
    end
    arbIf.begin_transactionIN = 1'b0;
    arbIf.errorIN             = 1'b1;
    @(negedge system_clock);
    arbIf.errorIN = 1'b0;
    checks++;
    if (arbIf.granted !== '0 || arbIf.bus_idle !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_error_release: granted=%b idle=%b expected 0000/1",
               arbIf.granted, arbIf.bus_idle);
    end
    @(negedge system_clock);
    lastServed = w;
  endtask

  task automatic test_timeout();
    int           w;
    logic [N-1:0] eg;
    arbIf.request = 4'b0001;
    w  = expWinner(4'b0001, lastServed);
    eg = oneHot(w);
`ifdef ARB_GRANT_TIMEOUT_EN
    for (int c = 1; c <= TMO; c++) begin
      @(negedge system_clock);
      checks++;
      if (arbIf.granted !== eg || arbIf.timeout_pulse !== 1'b0) begin
        failures++;
        $display("[TB] FAIL to_hold_cycle%0d: granted=%b tpulse=%b expected %b/0",
                 c, arbIf.granted, arbIf.timeout_pulse, eg);
      end
    end
    arbIf.request = 4'b1001;
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== '0 || arbIf.timeout_pulse !== 1'b1) begin
      failures++;
      $display("[TB] FAIL to_revoke: granted=%b tpulse=%b expected 0000/1",
               arbIf.granted, arbIf.timeout_pulse);
    end
    lastServed = w;
    w = expWinner(4'b1001, lastServed);
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== '0 || arbIf.timeout_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL to_pulse_width: granted=%b tpulse=%b expected 0000/0",
               arbIf.granted, arbIf.timeout_pulse);
    end
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== oneHot(w)) begin
      failures++;
      $display("[TB] FAIL to_next_grant: granted=%b expected=%b", arbIf.granted, oneHot(w));
    end
`else
    repeat (TMO + 24) begin
      @(negedge system_clock);
      checks++;
      if (arbIf.granted !== eg || arbIf.timeout_pulse !== 1'b0) begin
        failures++;
        $display("[TB] FAIL no_timeout_hold: granted=%b tpulse=%b expected %b/0",
                 arbIf.granted, arbIf.timeout_pulse, eg);
      end
    end
`endif
    arbIf.request = '0;
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== '0) begin
      failures++;
      $display("[TB] FAIL to_withdraw: granted=%b expected=0000", arbIf.granted);
    end
    @(negedge system_clock);
    lastServed = w;
  endtask

  task automatic test_reset_mid_busy();
    arbIf.request = 4'b0010;
    @(negedge system_clock);
    arbIf.begin_transactionIN = 1'b1;
    @(negedge system_clock);
    arbIf.begin_transactionIN = 1'b0;
    #2 system_reset = 1'b0;
    #1;
    checks++;
    if (arbIf.granted !== '0 || arbIf.bus_idle !== 1'b1 || arbIf.active_master !== 2'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: granted=%b idle=%b active=%0d expected 0000/1/0",
               arbIf.granted, arbIf.bus_idle, arbIf.active_master);
    end
    @(negedge system_clock);
    system_reset  = 1'b1;
    lastServed    = N - 1;
    arbIf.request = 4'b1111;
    @(negedge system_clock);
    checks++;
    if (arbIf.granted !== oneHot(expWinner(4'b1111, lastServed))) begin
      failures++;
      $display("[TB] FAIL reset_pointer: granted=%b expected=%b",
               arbIf.granted, oneHot(expWinner(4'b1111, lastServed)));
    end
    lastServed    = expWinner(4'b1111, lastServed);
    arbIf.request = '0;
    @(negedge system_clock);
    @(negedge system_clock);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      runTransaction(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_single_beat();
    test_busy_hold();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
